// File: rtl/mem_access_pkg.sv
// mem_access_pkg: opcodes, bus size codes, FSM encodings and decode helpers for the MEM stage
package mem_access_pkg;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  wreg;
        logic        rw;
        logic        m2r;
        logic        mw;
        logic [31:0] inst;
        logic [31:0] pc;
    } ex_mem_t;
    // Non-memory opcodes fall back to byte so an idle/reset stage drives size 0.
    function automatic logic [1:0] op_size(input logic [5:0] op);
        return (op == OP_LB || op == OP_LBU || op == OP_SB) ? SIZE_B :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? SIZE_H :
               (op == OP_LW || op == OP_SW) ? SIZE_W : SIZE_B;
    endfunction
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == SIZE_H && a[0]) || (size == SIZE_W && a != 2'b00);
    endfunction
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: SRAM-like data bus (req/addr_ok/data_ok)
//   master drives req, wr, size, addr, wdata; slave drives addr_ok, data_ok, rdata
interface mem_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;
    modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_access_load_align.sv
// mem_load_align: combinational load lane select and sign/zero extension
//   op (opcode), addr (byte offset), rdata (raw bus word) in; data (extended load value) out
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sgn;
    always_comb begin
        b    = rdata[{addr, 3'b000} +: 8];
        h    = addr[1] ? rdata[31:16] : rdata[15:0];
        sgn  = (op == OP_LB) || (op == OP_LH);
        data = op_size(op) == SIZE_B ? {{24{sgn & b[7]}}, b} :
               op_size(op) == SIZE_H ? {{16{sgn & h[15]}}, h} : rdata;
    end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage issuing loads/stores on an SRAM-like bus
//   clk/rst, stall_in and the EX->MEM *_in bundle in; bus (mem_access_if.master);
//   mem_stall plus the MEM->WB bundle (wb_result, wb_reg, wb_we, inst_out, pc_out) out.
//   MEM_ALIGN_CHECK_EN adds adel/ades and suppresses misaligned accesses.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        adel,
    output logic        ades,
`endif
    input  logic        stall_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  write_reg_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [31:0] inst_in,
    input  logic [31:0] pc_in,
    mem_access_if.master bus,
    output logic        mem_stall,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_reg,
    output logic        wb_we,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out
);
    ex_mem_t           latch_q, latch_d, in_b;
    logic [1:0]        state_q, state_d, size;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic [31:0]       sd, load_data;
    logic              capture, go;
    assign mem_stall = (state_q == S_REQ) || (state_q == S_WAIT);
    assign capture   = !stall_in && !mem_stall;
`ifdef MEM_ALIGN_CHECK_EN
    logic adel_q, adel_d, ades_q, ades_d, mis_in;
    assign mis_in = misaligned(op_size(inst_in[31:26]), mem_addr_in[1:0]);
    assign go     = (mem_read_in || mem_write_in) && !mis_in;
    assign adel   = adel_q;
    assign ades   = ades_q;
    assign wb_we  = latch_q.rw && !mem_stall && !adel_q && !ades_q;
    always_comb begin
        adel_d = capture ? (mem_read_in && mis_in) : adel_q;
        ades_d = capture ? (mem_write_in && mis_in) : ades_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            adel_q <= 1'b0;
            ades_q <= 1'b0;
        end else begin
            adel_q <= adel_d;
            ades_q <= ades_d;
        end
    end
`else
    assign go    = mem_read_in || mem_write_in;
    assign wb_we = latch_q.rw && !mem_stall;
`endif
    always_comb begin
        in_b    = '{alu: alu_result_in, addr: mem_addr_in, sdata: store_data_in, wreg: write_reg_in,
                    rw: reg_write_in, m2r: mem_to_reg_in, mw: mem_write_in, inst: inst_in, pc: pc_in};
        latch_d = capture ? in_b : latch_q;
        // IDLE and DONE behave alike: leave only when this cycle captures a memory op.
        state_d = state_q == S_REQ  ? (bus.addr_ok ? S_WAIT : S_REQ) :
                  state_q == S_WAIT ? (bus.data_ok ? S_DONE : S_WAIT) :
                  (capture && go)   ? S_REQ : S_IDLE;
        rbuf_d  = (state_q == S_WAIT && bus.data_ok) ? bus.rdata : rbuf_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q <= '0;
            state_q <= S_IDLE;
            rbuf_q  <= '0;
        end else begin
            latch_q <= latch_d;
            state_q <= state_d;
            rbuf_q  <= rbuf_d;
        end
    end
    assign size      = op_size(latch_q.inst[31:26]);
    assign sd        = latch_q.sdata;
    assign bus.req   = state_q == S_REQ;
    assign bus.wr    = latch_q.mw;
    assign bus.size  = size;
    assign bus.addr  = latch_q.addr[ADDR_W-1:0];
    assign bus.wdata = size == SIZE_B ? {4{sd[7:0]}} : size == SIZE_H ? {2{sd[15:0]}} : sd;
    mem_load_align u_align (
        .op    (latch_q.inst[31:26]),
        .addr  (latch_q.addr[1:0]),
        .rdata (rbuf_q),
        .data  (load_data)
    );
    assign wb_result = latch_q.m2r ? load_data : latch_q.alu;
    assign wb_reg    = latch_q.wreg;
    assign inst_out  = latch_q.inst;
    assign pc_out    = latch_q.pc;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench with a word-array memory model and a latency-programmable bus slave
module tb_mem_access;
    import mem_access_pkg::*;
    logic clk = 0, rst = 1, stall_in = 0;
    logic [31:0] alu_result_in, mem_addr_in, store_data_in, inst_in, pc_in;
    logic [4:0]  write_reg_in;
    logic        reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in;
    logic        mem_stall, wb_we;
    logic [31:0] wb_result, inst_out, pc_out;
    logic [4:0]  wb_reg;
`ifdef MEM_ALIGN_CHECK_EN
    logic adel, ades;
`endif
    mem_access_if bus ();
    mem_access dut (
        .clk(clk), .rst(rst),
`ifdef MEM_ALIGN_CHECK_EN
        .adel(adel), .ades(ades),
`endif
        .stall_in(stall_in), .alu_result_in(alu_result_in), .mem_addr_in(mem_addr_in),
        .store_data_in(store_data_in), .write_reg_in(write_reg_in), .reg_write_in(reg_write_in),
        .mem_to_reg_in(mem_to_reg_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .inst_in(inst_in), .pc_in(pc_in), .bus(bus), .mem_stall(mem_stall), .wb_result(wb_result),
        .wb_reg(wb_reg), .wb_we(wb_we), .inst_out(inst_out), .pc_out(pc_out)
    );
    always #5 clk = ~clk;

    typedef struct { logic wr; logic [1:0] size; logic [31:0] addr, wdata; } bus_t;
    typedef struct { logic [31:0] res, pc; logic [4:0] rg; } wb_t;
    bus_t        bus_q[$];
    wb_t         wb_q[$];
    logic [31:0] mem [16];
    int          checks = 0, failures = 0, ad_cfg = 0, dd_cfg = 0;
    logic [5:0]  ops [9] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 6'b000000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Write-back monitor: every wb_we pulse must match the oldest expected result.
    always @(negedge clk) begin
        wb_t e;
        if (wb_we === 1'b1) begin
            if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
            else begin
                e = wb_q.pop_front();
                chk("wb_result", wb_result, e.res);
                chk("wb_reg", wb_reg, e.rg);
                chk("wb_pc", pc_out, e.pc);
            end
        end
    end

    // Bus slave: checks request fields every REQ cycle, answers after programmed delays.
    initial begin
        int   cnt;
        bit   ph;
        bus_t e;
        cnt = 0; ph = 0;
        bus.addr_ok = 0; bus.data_ok = 0; bus.rdata = 0;
        forever begin
            @(negedge clk);
            bus.addr_ok = 0; bus.data_ok = 0; bus.rdata = $urandom;
            if (!ph && bus.req === 1'b1) begin
                if (bus_q.size() == 0) chk("bus_unexpected_req", 1, 0);
                else begin
                    e = bus_q[0];
                    chk("bus_wr", bus.wr, e.wr);
                    chk("bus_size", bus.size, e.size);
                    chk("bus_addr", bus.addr, e.addr);
                    if (e.wr) chk("bus_wdata", bus.wdata, e.wdata);
                    if (cnt == ad_cfg) begin
                        bus.addr_ok = 1; void'(bus_q.pop_front()); ph = 1; cnt = 0;
                    end else cnt++;
                end
            end else if (ph) begin
                if (cnt == dd_cfg) begin
                    bus.data_ok = 1; bus.rdata = mem[e.addr[5:2]]; ph = 0; cnt = 0;
                end else cnt++;
            end
        end
    end

    task automatic bubble();
        stall_in = 0; alu_result_in = 0; mem_addr_in = 0; store_data_in = 0; write_reg_in = 0;
        reg_write_in = 0; mem_to_reg_in = 0; mem_read_in = 0; mem_write_in = 0; inst_in = 0; pc_in = 0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] alu, input int ad, input int dd, input int hold);
        logic        mr, mw;
        logic [31:0] inst, pc, w, v, wd;
        logic [4:0]  rg;
        int          sz, a, n;
        mr = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
        mw = op inside {OP_SB, OP_SH, OP_SW};
        sz = (op inside {OP_LB, OP_LBU, OP_SB}) ? 1 : (op inside {OP_LH, OP_LHU, OP_SH}) ? 2 : 4;
        inst = {op, 26'($urandom)}; pc = $urandom; rg = 5'($urandom);
        a = int'(addr[1:0]); w = mem[addr[5:2]];
        v = sz == 4 ? w : (w >> (8 * a)) & ((32'd1 << (8 * sz)) - 1);
        if (op == OP_LB && v[7])  v = v | 32'hFFFF_FF00;
        if (op == OP_LH && v[15]) v = v | 32'hFFFF_0000;
        wd = sz == 1 ? (sd & 32'hFF) * 32'h0101_0101 : sz == 2 ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
        if (mw) for (int k = 0; k < sz; k++) mem[addr[5:2]][8 * (a + k) +: 8] = sd[8 * k +: 8];
        if (mr || mw) bus_q.push_back('{wr: mw, size: 2'(sz / 2), addr: addr, wdata: wd});
        if (!mw) wb_q.push_back('{res: mr ? v : alu, pc: pc, rg: rg});
        ad_cfg = ad; dd_cfg = dd;
        alu_result_in = alu; mem_addr_in = addr; store_data_in = sd; write_reg_in = rg;
        reg_write_in = !mw; mem_to_reg_in = mr; mem_read_in = mr; mem_write_in = mw;
        inst_in = inst; pc_in = pc; stall_in = hold > 0;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_inst", inst_out, 32'h0);
        end
        stall_in = 0;
        @(posedge clk); #1;
        bubble();
        n = 0;
        while (mem_stall === 1'b1 && n < 40) begin
            chk("stall_pc", pc_out, pc);
            stall_in = 1'($urandom); pc_in = $urandom;
            @(posedge clk); #1;
            n++;
        end
        stall_in = 0; pc_in = 0;
        chk("stall_cycles", n, (mr || mw) ? ad + dd + 2 : 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        bubble();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", mem_stall, 0);
        chk("rst_req", bus.req, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_result", wb_result, 0);
        chk("rst_inst", inst_out, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_size", bus.size, 0);
        chk("rst_wdata", bus.wdata, 0);
        rst = 0;
        issue(OP_SW,  32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0);
        issue(OP_SW,  32'h100, 32'h80FF_1234, 0, 0, 0, 0);
        issue(OP_LB,  32'h103, 0, 0, 0, 0, 0);
        issue(OP_LBU, 32'h103, 0, 0, 0, 0, 0);
        issue(OP_SW,  32'h100, 32'h8001_7FFF, 0, 0, 0, 0);
        issue(OP_LH,  32'h102, 0, 0, 0, 0, 0);
        issue(OP_LHU, 32'h100, 0, 0, 0, 0, 0);
        issue(OP_SW,  32'h108, $urandom, 0, 2, 1, 3);
        issue(6'b000000, 0, 0, 32'h55, 0, 0, 0);
        // Reset while waiting for data; the late data_ok must not write back.
        ad_cfg = 0; dd_cfg = 6;
        bus_q.push_back('{wr: 1'b0, size: SIZE_W, addr: 32'h104, wdata: 32'h0});
        mem_addr_in = 32'h104; reg_write_in = 1; mem_to_reg_in = 1; mem_read_in = 1;
        write_reg_in = 5'd7; inst_in = {OP_LW, 26'h0}; pc_in = 32'h400;
        @(posedge clk); #1;
        bubble();
        @(posedge clk); #1;
        chk("wait_stall", mem_stall, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("midrst_stall", mem_stall, 0);
        chk("midrst_req", bus.req, 0);
        chk("midrst_wb_we", wb_we, 0);
        chk("midrst_wb_result", wb_result, 0);
        chk("midrst_inst", inst_out, 0);
        chk("midrst_pc", pc_out, 0);
        chk("midrst_addr", bus.addr, 0);
        repeat (9) @(posedge clk);
        #1;
        chk("stray_stall", mem_stall, 0);
        chk("stray_req", bus.req, 0);
        for (int i = 0; i < 80; i++) begin
            logic [5:0]  op;
            logic [31:0] ad;
            int          sz;
            op = ops[$urandom_range(0, 8)];
            sz = (op inside {OP_LB, OP_LBU, OP_SB}) ? 1 : (op inside {OP_LH, OP_LHU, OP_SH}) ? 2 : 4;
            ad = 32'h100 + ($urandom_range(0, 63) & ~(sz - 1));
            issue(op, ad, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end
`ifdef MEM_ALIGN_CHECK_EN
        mem_addr_in = 32'h102; reg_write_in = 1; mem_to_reg_in = 1; mem_read_in = 1;
        inst_in = {OP_LW, 26'h0}; pc_in = 32'h500;
        @(posedge clk); #1;
        bubble();
        chk("align_adel", adel, 1);
        chk("align_ades", ades, 0);
        chk("align_stall", mem_stall, 0);
        chk("align_req", bus.req, 0);
        chk("align_wb_we", wb_we, 0);
        @(posedge clk); #1;
        chk("align_adel_clear", adel, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("wb_queue_drained", wb_q.size(), 0);
        chk("bus_queue_drained", bus_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the cqu_mips five-stage pipeline. It consumes the EX→MEM bundle: ALU result, memory address, read/write flags, write-back register, instruction and PC.
- Issues load/store transactions on an SRAM-like data bus (req/addr_ok/data_ok), aligns store data and extracts/extends load data, and drives the MEM→WB bundle.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- ADDR_W, 32, data bus address width
- DATA_W, 32, data bus data width (only 32 supported)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall_in  in  1  hazard-unit stall; holds the input latch
- alu_result_in  in  32  EX result
- mem_addr_in  in  32  effective address
- store_data_in  in  32  rt value for stores
- write_reg_in  in  5  destination register
- reg_write_in  in  1  register write enable
- mem_to_reg_in  in  1  select load data for WB
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- inst_in  in  32  instruction (opcode selects width/sign)
- pc_in  in  32  PC
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  byte address
- data_wdata  out  32  replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write done
- data_rdata  in  32  read data
- mem_stall  out  1  transaction outstanding
- wb_result  out  32  value to write back
- wb_reg  out  5  destination register
- wb_we  out  1  register write enable
- inst_out  out  32  latched instruction
- pc_out  out  32  latched PC

Behaviour:
- **Input latch:** all *_in are captured on posedge when !stall_in && !mem_stall. Otherwise the latch holds.
- **Reset:** clears every latch to 0 and puts the FSM in IDLE. All outputs are then 0, mem_stall=0 and data_req=0.
- **FSM states:** IDLE, REQ, WAIT, DONE.
  - IDLE/DONE → REQ when the cycle's capture has mem_read_in|mem_write_in=1.
  - IDLE/DONE → IDLE when a capture has no memory op, or when there is no capture.
  - REQ → WAIT on data_addr_ok.
  - WAIT → DONE on data_data_ok; data_rdata is registered into the load buffer in that cycle.
  - data_data_ok is ignored in IDLE, REQ and DONE.
- **Bus outputs:** data_req=1 only in REQ. data_addr, data_wr, data_size and data_wdata are stable from REQ until addr_ok.
- **mem_stall:** combinational, = (state==REQ || state==WAIT).
- **Minimum latency:** capture edge → REQ (addr_ok same cycle) → WAIT (data_ok) → DONE. That is 2 stall cycles.
- **Width decode** from opcode inst[31:26]:
  - LB 100000, LBU 100100, SB 101000 → size 0
  - LH 100001, LHU 100101, SH 101001 → size 1
  - LW 100011, SW 101011 → size 2
- **Store data:** sb {4{d[7:0]}}, sh {2{d[15:0]}}, sw d.
- **Load extract** (little-endian, by addr[1:0]):
  - byte lane = rdata[8*a+7 : 8*a]
  - half lane = addr[1] ? rdata[31:16] : rdata[15:0]
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **WB outputs:**
  - wb_result = mem_to_reg ? extracted load data : latched alu_result.
  - wb_reg = latched write_reg.
  - wb_we = latched reg_write && !mem_stall.
  - inst_out and pc_out are latched copies.
- **Reset mid-transaction:** returns to IDLE immediately. A late data_data_ok is ignored.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- **Defined:**
  - Adds output ports adel (misaligned load) and ades (misaligned store), registered with the latch.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - A misaligned op never leaves IDLE (no data_req), and wb_we is forced to 0.
- **Undefined:** no extra ports. Low address bits are passed unchanged and the access is issued.

Decomposition:
- Shared package/header (defines.vh): opcode constants (LB…SW), size encodings (SIZE_B/H/W) and FSM state encodings.
- Sub-module: mem_load_align. It is combinational: opcode, addr[1:0] and rdata in; extended load data out. It is reused by the WB forwarding path.

Test Plan:
1. SW, addr 0x100, data 0xDEADBEEF; addr_ok on 1st REQ cycle, data_ok 1 cycle later → data_req 1 cycle with wr=1, size=2, wdata=0xDEADBEEF; mem_stall high exactly 2 cycles; wb_we=0.
2. LB at 0x103, rdata 0x80FF_1234 → wb_result=0xFFFFFF80. LBU at the same address → 0x00000080. wb_we=1 only in DONE.
3. LH at 0x102, rdata 0x8001_7FFF → 0xFFFF8001. LHU at 0x100 → 0x00007FFF.
4. addr_ok delayed 3 cycles, data_ok delayed 2 more → data_req/addr/wdata stable across the waits; mem_stall high 5 cycles; input latch unchanged while stall_in toggles.
5. rst pulsed in WAIT, then data_ok arrives → state IDLE; all outputs 0; the stray data_ok produces no wb_we.
6. ADDU result 0x55 (no memory op) with stall_in=0 → no data_req; wb_result=0x55 and wb_we=1 one cycle after capture. With MEM_ALIGN_CHECK_EN, LW at 0x102 → adel=1, no data_req.
